// File: rtl/numlock_code_sender.sv
// Plays a stored combination into the number lock as timed u/z button pulses, then waits for unlock.
// Build option NUMLOCK_SENDER_RETRY_EN: after a timeout, stay quiet and resend the whole code once.
module numlock_code_sender #(
  parameter int CODE_LEN       = 4,
  parameter int PRESS_CYCLES   = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                unlock,
`ifdef NUMLOCK_SENDER_RETRY_EN
  output logic                retried,
`endif
  output logic                u,
  output logic                z,
  output logic                busy,
  output logic                done,
  output logic                success
);

  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef NUMLOCK_SENDER_RETRY_EN
  localparam logic [CNT_W-1:0] REGAP_LOAD   = CNT_W'(2 * GAP_CYCLES - 1);
`endif

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(CODE_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_FIN     = 3'd4,
    ST_REGAP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic                success_q, success_d;
  logic                u_q, u_d;
  logic                z_q, z_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                press_d;
  logic                bit_d;
`ifdef NUMLOCK_SENDER_RETRY_EN
  logic                second_q, second_d;
  logic                retried_q, retried_d;
`endif

  // Next-state logic; the phase counter is reloaded on every state entry and counts down to zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    code_d    = code_q;
    success_d = success_q;
`ifdef NUMLOCK_SENDER_RETRY_EN
    second_d  = second_q;
    retried_d = retried_q;
`endif
    case (state_q)
      // busy is already low in FIN, so a start there is accepted like in IDLE
      ST_IDLE, ST_FIN: begin
        if (start) begin
          state_d   = ST_PRESS;
          cnt_d     = PRESS_LOAD;
          idx_d     = IDX_MSB;
          code_d    = code;
          success_d = 1'b0;
`ifdef NUMLOCK_SENDER_RETRY_EN
          second_d  = 1'b0;
          retried_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_PRESS: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_RELEASE;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (idx_q == IDX_ZERO) begin
          state_d = ST_WAIT;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          state_d = ST_PRESS;
          cnt_d   = PRESS_LOAD;
          idx_d   = idx_q - IDX_ONE;
        end
      end
      ST_WAIT: begin
        if (unlock) begin
          state_d   = ST_FIN;
          cnt_d     = CNT_ZERO;
          success_d = 1'b1;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
`ifdef NUMLOCK_SENDER_RETRY_EN
        end else if (!second_q) begin
          // quiet period lets the lock drop back to its initial state before the resend
          state_d   = ST_REGAP;
          cnt_d     = REGAP_LOAD;
          second_d  = 1'b1;
          retried_d = 1'b1;
`endif
        end else begin
          state_d   = ST_FIN;
          cnt_d     = CNT_ZERO;
          success_d = 1'b0;
        end
      end
`ifdef NUMLOCK_SENDER_RETRY_EN
      ST_REGAP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_PRESS;
          cnt_d   = PRESS_LOAD;
          idx_d   = IDX_MSB;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    press_d = (state_d == ST_PRESS);
    bit_d   = code_d[idx_d];
    u_d     = press_d & bit_d;
    z_d     = press_d & ~bit_d;
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_FIN);
    done_d  = (state_d == ST_FIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      idx_q     <= IDX_ZERO;
      code_q    <= {CODE_LEN{1'b0}};
      success_q <= 1'b0;
      u_q       <= 1'b0;
      z_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef NUMLOCK_SENDER_RETRY_EN
      second_q  <= 1'b0;
      retried_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      success_q <= success_d;
      u_q       <= u_d;
      z_q       <= z_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef NUMLOCK_SENDER_RETRY_EN
      second_q  <= second_d;
      retried_q <= retried_d;
`endif
    end
  end

  assign u       = u_q;
  assign z       = z_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign success = success_q;
`ifdef NUMLOCK_SENDER_RETRY_EN
  assign retried = retried_q;
`endif

endmodule

// File: tb/tb_numlock_code_sender.sv
// Directed bench for numlock_code_sender with PRESS=2, GAP=2, TIMEOUT=8 and a small lock model.
module tb_numlock_code_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] code;
  logic       unlock;
  logic       u, z, busy, done, success;
`ifdef NUMLOCK_SENDER_RETRY_EN
  logic       retried;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // lock model: records rising edges of u/z as digits and opens on 1011
  logic       lock_en;
  logic       force_unlock;
  logic [3:0] hist;
  int         ndig;
  logic       u_prev, z_prev;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!lock_en) begin
      hist   <= 4'b0000;
      ndig   <= 0;
      u_prev <= 1'b0;
      z_prev <= 1'b0;
    end else begin
      u_prev <= u;
      z_prev <= z;
      if (u && !u_prev) begin
        hist <= {hist[2:0], 1'b1};
        ndig <= ndig + 1;
      end else if (z && !z_prev) begin
        hist <= {hist[2:0], 1'b0};
        ndig <= ndig + 1;
      end
    end
  end

  assign unlock = force_unlock | (lock_en && (ndig >= 4) && (hist == 4'b1011));

  numlock_code_sender #(
    .CODE_LEN(4), .PRESS_CYCLES(2), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .code(code), .unlock(unlock),
`ifdef NUMLOCK_SENDER_RETRY_EN
    .retried(retried),
`endif
    .u(u), .z(z), .busy(busy), .done(done), .success(success)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // expected {u,z,busy,done} in cycle k after the accepted start edge
  function automatic logic [3:0] exp_vec(input logic [3:0] c, input int k, input int done_k);
    int d;
    int ph;
    if (k == done_k) return 4'b0001;
    if (k > done_k) return 4'b0000;
    if (k >= 1 && k <= 16) begin
      d  = (k - 1) / 4;
      ph = (k - 1) % 4;
      if (ph < 2) return {c[3-d], ~c[3-d], 1'b1, 1'b0};
      return 4'b0010;
    end
    return 4'b0010;
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; code = 4'b0000;
    step; step;
    n_checks++;
    if ({u, z, busy, done, success} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_outputs: {u,z,busy,done,success}=%b expected 00000", {u, z, busy, done, success});
    end
    rst = 1'b0;
    step; step;
    n_checks++;
    if ({u, z, busy, done, success} !== 5'b00000) begin
      n_fail++;
      $display("FAIL idle_after_reset: {u,z,busy,done,success}=%b expected 00000", {u, z, busy, done, success});
    end
`ifdef NUMLOCK_SENDER_RETRY_EN
    n_checks++;
    if (retried !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_retried: got %b expected 0", retried);
    end
`endif
  endtask

  task automatic test_correct_code;
    logic [3:0] obs, expv;
    lock_en = 1'b0; step; lock_en = 1'b1;
    code = 4'b1011; start = 1'b1; step; start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      obs = {u, z, busy, done}; expv = exp_vec(4'b1011, k, 18);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL correct_code k=%0d: {u,z,busy,done}=%b expected %b", k, obs, expv);
      end
      if (k == 18 || k == 20) begin
        n_checks++;
        if (success !== 1'b1) begin
          n_fail++;
          $display("FAIL correct_code_success k=%0d: got %b expected 1", k, success);
        end
      end
      step;
    end
  endtask

  task automatic test_no_unlock;
    logic [3:0] obs, expv;
    lock_en = 1'b0; step;
    code = 4'b1011; start = 1'b1; step; start = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      obs = {u, z, busy, done}; expv = exp_vec(4'b1011, k, 25);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL no_unlock k=%0d: {u,z,busy,done}=%b expected %b", k, obs, expv);
      end
      if (k == 1 || k == 25) begin
        n_checks++;
        if (success !== 1'b0) begin
          n_fail++;
          $display("FAIL no_unlock_success k=%0d: got %b expected 0", k, success);
        end
      end
      step;
    end
  endtask

  task automatic test_start_while_busy;
    logic [3:0] obs, expv;
    lock_en = 1'b0; step; lock_en = 1'b1;
    code = 4'b1011; start = 1'b1; step; start = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      obs = {u, z, busy, done}; expv = exp_vec(4'b1011, k, 18);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL start_while_busy k=%0d: {u,z,busy,done}=%b expected %b", k, obs, expv);
      end
      if (k == 18) begin
        n_checks++;
        if (success !== 1'b1) begin
          n_fail++;
          $display("FAIL start_while_busy_success: got %b expected 1", success);
        end
      end
      start = (k == 5);
      code  = (k == 5) ? 4'b0000 : 4'b1011;
      step;
    end
    start = 1'b0; code = 4'b1011;
  endtask

  task automatic test_reset_mid_send;
    logic [3:0] obs, expv;
    lock_en = 1'b0; step;
    code = 4'b1011; start = 1'b1; step; start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      obs = {u, z, busy, done}; expv = exp_vec(4'b1011, k, 99);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL mid_send_prefix k=%0d: {u,z,busy,done}=%b expected %b", k, obs, expv);
      end
      if (k < 9) step;
    end
    rst = 1'b1; step;
    n_checks++;
    if ({u, z, busy, done, success} !== 5'b00000) begin
      n_fail++;
      $display("FAIL mid_send_reset: {u,z,busy,done,success}=%b expected 00000", {u, z, busy, done, success});
    end
    start = 1'b1; step;
    n_checks++;
    if ({u, z, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL start_with_reset: {u,z,busy}=%b expected 000", {u, z, busy});
    end
    rst = 1'b0; start = 1'b0; step;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_reset_idle: busy=%b expected 0", busy);
    end
    lock_en = 1'b1;
    start = 1'b1; step; start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      obs = {u, z, busy, done}; expv = exp_vec(4'b1011, k, 18);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL resend_after_reset k=%0d: {u,z,busy,done}=%b expected %b", k, obs, expv);
      end
      if (k == 18) begin
        n_checks++;
        if (success !== 1'b1) begin
          n_fail++;
          $display("FAIL resend_after_reset_success: got %b expected 1", success);
        end
      end
      step;
    end
  endtask

  task automatic test_early_unlock;
    int lo_t   [4] = '{7, 24, 16, 17};
    int hi_t   [4] = '{8, 24, 16, 17};
    int dk_t   [4] = '{25, 25, 25, 18};
    logic sc_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] obs, expv;
    lock_en = 1'b0; step;
    for (int r = 0; r < 4; r++) begin
      code = 4'b1011; start = 1'b1; step; start = 1'b0;
      for (int k = 1; k <= dk_t[r] + 1; k++) begin
        obs = {u, z, busy, done}; expv = exp_vec(4'b1011, k, dk_t[r]);
        n_checks++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL early_unlock run=%0d k=%0d: {u,z,busy,done}=%b expected %b", r, k, obs, expv);
        end
        if (k == dk_t[r]) begin
          n_checks++;
          if (success !== sc_t[r]) begin
            n_fail++;
            $display("FAIL early_unlock_success run=%0d: got %b expected %b", r, success, sc_t[r]);
          end
        end
        force_unlock = (k >= lo_t[r]) && (k <= hi_t[r]);
        step;
      end
      force_unlock = 1'b0;
    end
  endtask

`ifdef NUMLOCK_SENDER_RETRY_EN
  task automatic test_retry;
    logic [3:0] obs, expv;
    lock_en = 1'b0; step;
    code = 4'b1011; start = 1'b1; step; start = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      if (k <= 16)      expv = exp_vec(4'b1011, k, 99);
      else if (k <= 28) expv = 4'b0010;
      else if (k <= 44) expv = exp_vec(4'b1011, k - 28, 99);
      else if (k < 47)  expv = 4'b0010;
      else if (k == 47) expv = 4'b0001;
      else              expv = 4'b0000;
      obs = {u, z, busy, done};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL retry k=%0d: {u,z,busy,done}=%b expected %b", k, obs, expv);
      end
      if (k == 24 || k == 25 || k == 47) begin
        n_checks++;
        if (retried !== (k != 24)) begin
          n_fail++;
          $display("FAIL retry_flag k=%0d: got %b expected %b", k, retried, (k != 24));
        end
      end
      if (k == 47) begin
        n_checks++;
        if (success !== 1'b1) begin
          n_fail++;
          $display("FAIL retry_success: got %b expected 1", success);
        end
      end
      force_unlock = (k == 46);
      step;
    end
    force_unlock = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; code = 4'b0000; lock_en = 1'b0; force_unlock = 1'b0;
    test_reset;
    test_correct_code;
    test_no_unlock;
    test_start_while_busy;
    test_reset_mid_send;
    test_early_unlock;
`ifdef NUMLOCK_SENDER_RETRY_EN
    test_retry;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
